// File: rtl/crc24b_pkg.sv
// Shared constants, FSM encoding and CRC-24B helpers for the CRC attach block.
package crc24b_pkg;

    localparam int MAX_PAYLOAD_BYTES   = 765;
    localparam int SMALL_PAYLOAD_BYTES = 129;
    localparam int ADDR_W              = $clog2(MAX_PAYLOAD_BYTES);

    localparam logic [23:0]       CRC_POLY  = 24'h800063;
    localparam logic [ADDR_W-1:0] LEN_SMALL = ADDR_W'(SMALL_PAYLOAD_BYTES);
    localparam logic [ADDR_W-1:0] LEN_LARGE = ADDR_W'(MAX_PAYLOAD_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_DS,
        HDR,
        SEND,
        CRC_OUT
    } state_t;

    // crc[23] is the D23 coefficient (p0); data bit 0 enters first.
    function automatic logic [23:0] crc24b_byte(input logic [23:0] crc, input logic [7:0] data);
        logic [23:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[23] ^ data[i];
            c  = {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
        end
        return c;
    endfunction

    // CRC byte k carries p[8k+i] in bit i, i.e. crc[23-8k-i].
    function automatic logic [7:0] crc24b_out_byte(input logic [23:0] crc, input logic [1:0] idx);
        logic [23:0] s;
        logic [7:0]  b;
        s = crc << (5'd8 * 5'(idx));
        for (int i = 0; i < 8; i++) begin
            b[i] = s[23-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/crc24b_attach_payload_buf.sv
// Single-port payload RAM, read-first, one-cycle registered read.
module payload_buf
    import crc24b_pkg::*;
#(
    parameter int DEPTH = MAX_PAYLOAD_BYTES
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/crc24b_attach.sv
// Loads one code-block payload, computes CRC-24B on the fly, then streams
// payload + 3 CRC bytes to the turbo interleaver after a one-cycle header pulse.
module crc24b_attach
    import crc24b_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_src_vld,
    input  logic       i_src_cbs,
    input  logic [7:0] i_src_data,
    output logic       o_src_rdy,
    input  logic       i_rdy_crc,
    output logic       o_vld_crc,
    output logic       o_cbs,
    output logic [7:0] o_data_out
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc, w_len;
    logic [23:0]       r_crc, w_crc_nxt;
    logic              r_cbs, w_cbs_nxt;
    logic              r_cbs_out, w_cbs_out_nxt;
    logic              r_src_rdy;
    logic              w_accept, w_we;
    logic [7:0]        w_rdata;

    assign w_accept  = i_src_vld && r_src_rdy;
    assign w_len     = r_cbs ? LEN_LARGE : LEN_SMALL;
    assign w_cnt_inc = r_cnt + ADDR_W'(1);

    // r_cnt doubles as the RAM address: write pointer in LOAD, read pointer
    // in HDR/SEND (kept 0 in IDLE/WAIT_DS/HDR), CRC byte index in CRC_OUT.
    payload_buf #(.DEPTH(MAX_PAYLOAD_BYTES)) u_buf (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (r_cnt),
        .i_wdata (i_src_data),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_crc_nxt     = r_crc;
        w_cbs_nxt     = r_cbs;
        w_cbs_out_nxt = r_cbs_out;
        w_we          = 1'b0;
        o_vld_crc     = 1'b0;
        o_data_out    = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_we        = 1'b1;
                    w_cbs_nxt   = i_src_cbs;
                    w_crc_nxt   = crc24b_byte(24'h0, i_src_data);
                    w_cnt_nxt   = ADDR_W'(1);
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (w_accept) begin
                    w_we      = 1'b1;
                    w_crc_nxt = crc24b_byte(r_crc, i_src_data);
                    if (w_cnt_inc == w_len) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = WAIT_DS;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            WAIT_DS: begin
                if (i_rdy_crc) begin
                    w_cbs_out_nxt = r_cbs;
                    w_state_nxt   = HDR;
                end
            end
            HDR: begin
                // Address 0 is presented this cycle so byte 0 lands next cycle.
                o_vld_crc   = 1'b1;
                w_cnt_nxt   = ADDR_W'(1);
                w_state_nxt = SEND;
            end
            SEND: begin
                o_data_out = w_rdata;
                if (r_cnt == w_len) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = CRC_OUT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            CRC_OUT: begin
                o_data_out = crc24b_out_byte(r_crc, r_cnt[1:0]);
                if (r_cnt == ADDR_W'(2)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_crc     <= '0;
            r_cbs     <= 1'b0;
            r_cbs_out <= 1'b0;
            r_src_rdy <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_crc     <= w_crc_nxt;
            r_cbs     <= w_cbs_nxt;
            r_cbs_out <= w_cbs_out_nxt;
            r_src_rdy <= (w_state_nxt == IDLE) || (w_state_nxt == LOAD);
        end
    end

    assign o_src_rdy = r_src_rdy;
    assign o_cbs     = r_cbs_out;

endmodule

// File: tb/tb_crc24b_attach.sv
// Directed bench for crc24b_attach: reset, zero block, single-bit CRC,
// large block with gaps and held rdy_crc, mid-load reset, back-to-back blocks.
module tb_crc24b_attach;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       src_vld = 1'b0;
    logic       src_cbs = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_rdy;
    logic       rdy_crc = 1'b0;
    logic       vld_crc;
    logic       cbs;
    logic [7:0] data_out;

    int checks = 0;
    int passes = 0;

    int   rem_bytes = 0;
    int   vld_cnt = 0;
    int   rdy_viol = 0;
    bq_t  out_q;
    logic hdr_q[$];

    crc24b_attach dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_src_vld  (src_vld),
        .i_src_cbs  (src_cbs),
        .i_src_data (src_data),
        .o_src_rdy  (src_rdy),
        .i_rdy_crc  (rdy_crc),
        .o_vld_crc  (vld_crc),
        .o_cbs      (cbs),
        .o_data_out (data_out)
    );

    always #5 clk = ~clk;

    // Output collector: after each vld_crc grab the next 132/768 bytes.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            rem_bytes = 0;
        end else begin
            if ((rem_bytes > 0 || vld_crc) && src_rdy) rdy_viol++;
            if (vld_crc) vld_cnt++;
            if (rem_bytes > 0) begin
                out_q.push_back(data_out);
                rem_bytes--;
            end else if (vld_crc) begin
                hdr_q.push_back(cbs);
                rem_bytes = cbs ? 768 : 132;
            end
        end
    end

    // Reference: remainder of M(x)*x^24 by long division, message bit 0 of byte 0 first.
    task automatic ref_crc(input bq_t msg, output logic [7:0] c0, output logic [7:0] c1, output logic [7:0] c2);
        logic [23:0] r;
        logic        top;
        r = '0;
        for (int n = 0; n < msg.size() * 8 + 24; n++) begin
            top = r[23];
            r   = {r[22:0], (n < msg.size() * 8) ? msg[n/8][n%8] : 1'b0};
            if (top) r = r ^ 24'h800063;
        end
        for (int i = 0; i < 8; i++) begin
            c0[i] = r[23-i];
            c1[i] = r[15-i];
            c2[i] = r[7-i];
        end
    endtask

    task automatic expected_stream(input bq_t msg, output bq_t exp);
        logic [7:0] c0, c1, c2;
        ref_crc(msg, c0, c1, c2);
        exp = msg;
        exp.push_back(c0);
        exp.push_back(c1);
        exp.push_back(c2);
    endtask

    task automatic rand_bytes(input int n, output bq_t q);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    endtask

    task automatic drive_block(input logic bcbs, input bq_t bytes, input int gap_pct, output logic ok);
        int   i;
        int   cyc;
        logic v;
        logic acc;
        i   = 0;
        cyc = 0;
        while (i < bytes.size() && cyc < 20000) begin
            v        = ($urandom_range(99) >= gap_pct);
            src_vld  = v;
            src_cbs  = bcbs;
            src_data = bytes[i];
            acc      = v && src_rdy;
            @(posedge clk); #1;
            cyc++;
            if (acc) i++;
        end
        src_vld = 1'b0;
        ok = (i == bytes.size());
    endtask

    task automatic wait_out(input int n, output logic ok);
        int cyc;
        cyc = 0;
        while (out_q.size() < n && cyc < 5000) begin
            @(posedge clk); #2;
            cyc++;
        end
        ok = (out_q.size() >= n);
    endtask

    task automatic clear_capture();
        out_q.delete();
        hdr_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({src_rdy, vld_crc, cbs, data_out} !== 11'h0)
            $display("FAIL reset_outputs: got rdy=%b vld=%b cbs=%b data=%h, need all 0", src_rdy, vld_crc, cbs, data_out);
        else passes++;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (src_rdy !== 1'b1) $display("FAIL rdy_after_reset: got %b need 1", src_rdy);
        else passes++;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (vld_cnt !== 0) $display("FAIL idle_no_vld: got %0d pulses need 0", vld_cnt);
        else passes++;
    endtask

    task automatic test_zero_block();
        bq_t  msg;
        logic ok;
        int   bad;
        clear_capture();
        rdy_crc = 1'b1;
        msg = {};
        for (int i = 0; i < 129; i++) msg.push_back(8'h00);
        drive_block(1'b0, msg, 0, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL zero_load: got ok=%b need 1", ok);
        else passes++;
        wait_out(132, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ok !== 1'b1 || hdr_q.size() != 1) $display("FAIL zero_hdr: got ok=%b pulses=%0d need 1/1", ok, hdr_q.size());
        else if (hdr_q[0] !== 1'b0) $display("FAIL zero_hdr: got cbs=%b need 0", hdr_q[0]);
        else passes++;
        bad = 0;
        foreach (out_q[i]) if (out_q[i] !== 8'h00) bad++;
        checks++;
        if (bad != 0 || out_q.size() != 132) $display("FAIL zero_stream: got %0d nonzero of %0d bytes need 0 of 132", bad, out_q.size());
        else passes++;
        checks++;
        if (src_rdy !== 1'b1 || data_out !== 8'h00) $display("FAIL zero_idle: got rdy=%b data=%h need 1/00", src_rdy, data_out);
        else passes++;
    endtask

    task automatic test_last_bit();
        bq_t  msg;
        logic ok;
        int   bad;
        clear_capture();
        msg = {};
        for (int i = 0; i < 128; i++) msg.push_back(8'h00);
        msg.push_back(8'h80);
        drive_block(1'b0, msg, 0, ok);
        wait_out(132, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL lastbit_timeout: got %0d bytes need 132", out_q.size());
        else passes++;
        if (out_q.size() >= 132) begin
            bad = 0;
            for (int i = 0; i < 129; i++) if (out_q[i] !== msg[i]) bad++;
            checks++;
            if (bad != 0) $display("FAIL lastbit_payload: got %0d mismatches need 0", bad);
            else passes++;
            checks++;
            if (out_q[129] !== 8'h01) $display("FAIL lastbit_crc0: got %h need 01", out_q[129]);
            else passes++;
            checks++;
            if (out_q[130] !== 8'h00) $display("FAIL lastbit_crc1: got %h need 00", out_q[130]);
            else passes++;
            checks++;
            if (out_q[131] !== 8'hC6) $display("FAIL lastbit_crc2: got %h need c6", out_q[131]);
            else passes++;
        end
    endtask

    task automatic test_large_gaps();
        bq_t  msg, exp;
        logic ok;
        int   bad;
        clear_capture();
        rdy_crc = 1'b0;
        rand_bytes(765, msg);
        expected_stream(msg, exp);
        drive_block(1'b1, msg, 30, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL large_load: got ok=%b need 1", ok);
        else passes++;
        bad = 0;
        repeat (50) begin
            if (src_rdy !== 1'b0 || vld_crc !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) $display("FAIL large_hold: got %0d cycles with rdy/vld high need 0", bad);
        else passes++;
        rdy_crc = 1'b1;
        wait_out(768, ok);
        checks++;
        if (ok !== 1'b1 || hdr_q.size() != 1) $display("FAIL large_hdr: got ok=%b pulses=%0d need 1/1", ok, hdr_q.size());
        else if (hdr_q[0] !== 1'b1) $display("FAIL large_hdr: got cbs=%b need 1", hdr_q[0]);
        else passes++;
        bad = 0;
        for (int i = 0; i < 768; i++) if (i >= out_q.size() || out_q[i] !== exp[i]) bad++;
        checks++;
        if (bad != 0) $display("FAIL large_stream: got %0d mismatches need 0", bad);
        else passes++;
        if (out_q.size() >= 768) begin
            checks++;
            if ({out_q[765], out_q[766], out_q[767]} !== {exp[765], exp[766], exp[767]})
                $display("FAIL large_crc: got %h%h%h need %h%h%h", out_q[765], out_q[766], out_q[767], exp[765], exp[766], exp[767]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_load();
        bq_t  part, msg, exp;
        logic ok;
        int   v0, bad;
        clear_capture();
        rdy_crc = 1'b1;
        rand_bytes(60, part);
        drive_block(1'b0, part, 0, ok);
        v0 = vld_cnt;
        reset    = 1'b1;
        src_vld  = 1'b1;
        src_data = 8'hA5;
        @(posedge clk); #1;
        reset   = 1'b0;
        src_vld = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (vld_cnt != v0 || out_q.size() != 0) $display("FAIL abort_silent: got %0d pulses %0d bytes need 0/0", vld_cnt - v0, out_q.size());
        else passes++;
        rand_bytes(129, msg);
        expected_stream(msg, exp);
        drive_block(1'b0, msg, 10, ok);
        wait_out(132, ok);
        bad = 0;
        for (int i = 0; i < 132; i++) if (i >= out_q.size() || out_q[i] !== exp[i]) bad++;
        checks++;
        if (ok !== 1'b1 || bad != 0) $display("FAIL abort_next_block: got ok=%b mismatches=%0d need 1/0", ok, bad);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bq_t  a, b, exp, ea, eb;
        logic ok;
        int   bad;
        clear_capture();
        rdy_crc  = 1'b1;
        rdy_viol = 0;
        rand_bytes(129, a);
        rand_bytes(765, b);
        expected_stream(a, ea);
        expected_stream(b, eb);
        exp = {ea, eb};
        drive_block(1'b0, a, 0, ok);
        drive_block(1'b1, b, 0, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL b2b_load: got ok=%b need 1", ok);
        else passes++;
        wait_out(900, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hdr_q.size() != 2) $display("FAIL b2b_hdr: got %0d pulses need 2", hdr_q.size());
        else if ({hdr_q[0], hdr_q[1]} !== 2'b01) $display("FAIL b2b_hdr: got cbs %b%b need 01", hdr_q[0], hdr_q[1]);
        else passes++;
        bad = 0;
        for (int i = 0; i < 900; i++) if (i >= out_q.size() || out_q[i] !== exp[i]) bad++;
        checks++;
        if (bad != 0 || out_q.size() != 900) $display("FAIL b2b_stream: got %0d mismatches %0d bytes need 0/900", bad, out_q.size());
        else passes++;
        checks++;
        if (rdy_viol != 0) $display("FAIL b2b_rdy_low: got %0d busy cycles with src_rdy high need 0", rdy_viol);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_zero_block();
        test_last_bit();
        test_large_gaps();
        test_reset_mid_load();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
